bin_dec_strobe: RTL
===================

# bin_dec_strobe

Registered, handshaked successor to the combinational binary decoder. Accepts a binary index over a valid/ready interface, range-checks it against a configurable output count, and drives a one-hot strobe of programmable polarity. The strobe is either a pulse of programmable length or a level held until cleared. It sits between control sequencers and per-channel enable/select lines that need glitch-free, registered one-hot selects.

## Interface
- `IN`, 3, index width.
- `OUT`, `1 << IN`, number of output lines; legal range 1..2^IN.
- `ACT`, `` `High ``, active level of the selected output bit; every other bit drives `~ACT`.
- `LEN_W`, 4, width of the pulse-length field.

- `clk` in 1: clock.
- `reset_` in 1: reset; synchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `in` in `IN`: index to decode.
- `len` in `LEN_W`: pulse length minus one; sampled on accept.
- `mode` in 1: 0 = pulse, 1 = latch; sampled on accept.
- `clear` in 1: terminates the active strobe.
- `out` out `OUT`: registered one-hot strobe.
- `busy` out 1: strobe is active.
- `err` out 1: one-cycle flag for an out-of-range index.

## Operation
- The block has one clock and a synchronous, active-low reset.
- Reset values:
  - `out` = `{OUT{~ACT}}`.
  - `busy` = 0, `err` = 0.
  - State = IDLE, counter = 0.
  - `in_ready` = 0 while `reset_` is low.
- **Accept:** occurs when `in_valid && in_ready` is true at a rising edge.
- **Out-of-range accept** (`in >= OUT`):
  - `err` = 1 for exactly the next cycle.
  - `out` stays inactive and the state stays IDLE.
  - The request is consumed, not retried.
- **In-range accept:**
  - The next cycle, `out[in] = ACT` and all other bits = `~ACT`.
  - `busy` = 1.
  - The counter is loaded with `len`.
  - The state becomes PULSE (if `mode` = 0) or LATCH (if `mode` = 1).
- **States:**
  - **IDLE:** `in_ready` = 1.
  - **PULSE:** the counter decrements each cycle. When the counter = 0 and there is no new accept, go to IDLE next cycle with `out` inactive. The pulse width is therefore `len + 1` cycles.
  - **LATCH:** `out` holds indefinitely. `clear` = 1 → IDLE next cycle with `out` inactive.
- **`in_ready`** = `reset_ && (IDLE || (PULSE && cnt == 0))`. This allows back-to-back pulses with no gap.
  - A new accept in the last pulse cycle replaces `out` directly with the new one-hot value, or with the inactive pattern plus `err` if the new index is out of range.
  - In LATCH, `in_ready` = 0.
- **`clear`:**
  - In PULSE, `clear` aborts the pulse: IDLE next cycle, and any accept in that cycle is suppressed (`in_ready` forced 0 when `clear` = 1 outside IDLE).
  - In IDLE, `clear` is ignored.
- **Arithmetic:**
  - The counter is `LEN_W` bits; `len` = all-ones gives 2^LEN_W cycles.
  - The range compare is unsigned, with `in` zero-extended.
  - With `OUT` = 2^IN, `err` is never set.
- **Reset mid-operation:** reset returns all outputs to reset values on the next edge, regardless of state.

## Timing
- Accept at edge N → `out`/`busy`/`err` valid from cycle N+1. All outputs are registered.
- `in_ready` is the only combinational output; it depends only on state, counter, `clear` and `reset_`.
- Pulse mode: `busy` high for exactly `len + 1` cycles per accepted request.
- Latch release: `clear` sampled at edge M → `out` inactive and `busy` = 0 from cycle M+1. `in_ready` = 1 in cycle M+1.

## Structure
- Package `bin_dec_strobe_pkg`: state enum `{IDLE, PULSE, LATCH}`, plus the mode encodings `MODE_PULSE` = 0 and `MODE_LATCH` = 1.
- `` `High `` / `` `Low `` come from the shared standard definitions header.
- Sub-module: the existing `bin_dec` (`IN`, `ACT`) produces the one-hot pattern combinationally. Its low `OUT` bits feed the output register.

## Test plan
- Pulse width, `IN`=3, `ACT`=High: accept `in`=5, `len`=2, `mode`=0 → `out` = 8'h20 for exactly 3 cycles, then 8'h00. `busy` matches, `in_ready` = 1 in the 3rd cycle.
- Back-to-back pulses: accept `in`=1, `len`=0, then `in`=6 in the following cycle → `out` = 8'h02 then 8'h40 in consecutive cycles, with no idle gap.
- Latch and clear, `ACT`=Low: accept `in`=3, `mode`=1 → `out` = 8'hF7 held for 20 cycles with `in_ready` = 0. Pulse `clear` → `out` = 8'hFF next cycle and `in_ready` = 1.
- Out-of-range, `OUT`=6: accept `in`=7 → `err` = 1 for one cycle, `out` = 6'h00, `busy` = 0, state stays IDLE.
- Abort/reset:
  - `clear` in the 2nd cycle of a `len`=7 pulse → `out` inactive next cycle.
  - `reset_` = 0 mid-latch → reset values next edge, `in_ready` = 0 while reset is held.
- Exhaustive sweep: every index 0..7 in pulse mode with `len`=0 → exactly one active bit, at position `in`.

Source files
------------

// File: rtl/bin_dec_strobe_pkg.sv
// Shared types and constants for the registered one-hot strobe decoder.
package bin_dec_strobe_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_LATCH = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/bin_dec.sv
// Combinational binary-to-one-hot decoder with selectable active level.
module bin_dec
  import bin_dec_strobe_pkg::*;
#(
  parameter int unsigned IN  = 3,
  parameter logic        ACT = HIGH
) (
  input  logic [IN-1:0]      in,
  output logic [(2**IN)-1:0] out
);

  always_comb begin
    out     = {(2**IN){~ACT}};
    out[in] = ACT;
  end

endmodule

// File: rtl/bin_dec_strobe.sv
// Handshaked, range-checked one-hot strobe: a timed pulse or a level held until cleared.
module bin_dec_strobe
  import bin_dec_strobe_pkg::*;
#(
  parameter int unsigned IN    = 3,
  parameter int unsigned OUT   = 1 << IN,
  parameter logic        ACT   = HIGH,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN-1:0]    in,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic             clear,
  output logic [OUT-1:0]   out,
  output logic             busy,
  output logic             err
);

  localparam int unsigned    FULL     = 1 << IN;
  localparam logic [OUT-1:0] INACTIVE = {OUT{~ACT}};

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [OUT-1:0]   out_d;
  logic             busy_d, err_d;
  logic [FULL-1:0]  dec, dec_norm;
  logic             in_range, last, accept, load;

  bin_dec #(.IN(IN), .ACT(ACT)) u_dec (
    .in  (in),
    .out (dec)
  );

  // Any decoded bit at or above OUT means the index is out of range.
  assign dec_norm = dec ^ {FULL{~ACT}};
  assign in_range = (dec_norm >> OUT) == '0;

  assign last     = (state_q == PULSE) && (cnt_q == '0);
  assign in_ready = reset_ && !(clear && (state_q != IDLE)) && ((state_q == IDLE) || last);
  assign accept   = in_valid && in_ready;
  assign load     = accept && in_range;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out     <= INACTIVE;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

  // Next state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = (mode == MODE_LATCH) ? LATCH : PULSE;
          cnt_d   = len;
        end
      end
      PULSE: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (load) begin
            state_d = (mode == MODE_LATCH) ? LATCH : PULSE;
            cnt_d   = len;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      LATCH: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    out_d  = INACTIVE;
    busy_d = (state_d != IDLE);
    err_d  = accept && !in_range;
    if (load) begin
      out_d = dec[OUT-1:0];
    end else if (state_d != IDLE) begin
      out_d = out;
    end
  end

endmodule
